// File: rtl/hydra_pkt_gen.sv
// hydra_pkt_gen -- packet source for one hydra write port.
//
// Emits pkt_total packets per run. Each packet is a sop beat, a header beat
// carrying {len, prior, dest}, len body beats carrying the body index, and an
// eop beat. pause stalls body beats only. Length, priority and destination
// come from the fixed_* inputs, a 32-bit Galois LFSR, or an incrementing
// sequence, selected by mode.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           pulse: begin a run (ignored while busy)
//   mode            0/3 fixed, 1 random, 2 incrementing
//   fixed_len/prior/dest  packet fields in fixed mode (len 0 -> 1)
//   pkt_total       packets per run, sampled when start is accepted
//   pause           backpressure, stalls body beats
//   wr_sop/eop/vld/data   write-side beat interface
//   busy, done      run status
//   pkt_sent        packets whose eop has been emitted this run
//   beat_sent       body beats emitted with wr_vld=1 this run
module hydra_pkt_gen #(
  parameter int          DATA_W  = 16,
  parameter int          LEN_W   = 9,
  parameter int          PRI_W   = 3,
  parameter int          PORT_W  = 4,
  parameter int          MIN_LEN = 31,
  parameter int          MAX_LEN = 511,
  parameter int          CNT_W   = 32,
  parameter logic [31:0] SEED    = 32'h1ACE_B00C
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [LEN_W-1:0]  fixed_len,
  input  logic [PRI_W-1:0]  fixed_prior,
  input  logic [PORT_W-1:0] fixed_dest,
  input  logic [CNT_W-1:0]  pkt_total,
  input  logic              pause,
  output logic              wr_sop,
  output logic              wr_eop,
  output logic              wr_vld,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  pkt_sent,
  output logic [CNT_W-1:0]  beat_sent
);

  typedef enum logic [2:0] {S_IDLE, S_SOP, S_HDR, S_BODY, S_EOP, S_DONE} state_t;

  localparam logic [31:0]      SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0]      LFSR_MASK = 32'h8020_0003;
  localparam logic [LEN_W-1:0] MIN_L     = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L     = LEN_W'(MAX_LEN);

  state_t              state, next_state;
  logic [31:0]         lfsr, lfsr_next;
  logic [LEN_W-1:0]    cur_len, sel_len, raw, idx;
  logic [PRI_W-1:0]    cur_prior, sel_prior;
  logic [PORT_W-1:0]   cur_dest, sel_dest;
  logic [CNT_W-1:0]    total_q;
  logic                accept, first_pkt;
  logic                sop_d, eop_d, vld_d, beat_d, busy_d, done_d;
  logic [DATA_W-1:0]   data_d;

  assign accept    = start && (state == S_IDLE || state == S_DONE);
  assign first_pkt = (state == S_IDLE || state == S_DONE);
  assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'd0);
  assign raw       = lfsr[LEN_W-1:0];

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignment so every
    // flop samples pre-edge values regardless of statement order.
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic. pkt_sent already counts the current eop while in EOP.
  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    next_state = state;
    case (state)
      S_IDLE, S_DONE: if (start) next_state = (pkt_total == '0) ? S_DONE : S_SOP;
      S_SOP:          next_state = S_HDR;
      S_HDR:          next_state = (cur_len == '0) ? S_EOP : S_BODY;
      S_BODY:         if (idx == cur_len) next_state = S_EOP;
      S_EOP:          next_state = (pkt_sent < total_q) ? S_SOP : S_DONE;
      default:        next_state = S_IDLE;
    endcase
  end

  // Packet field selection, captured on entry to SOP.
  always_comb begin
    sel_len   = (fixed_len == '0) ? LEN_W'(1) : fixed_len;
    sel_prior = fixed_prior;
    sel_dest  = fixed_dest;
    case (mode)
      2'd1: begin
        sel_len   = (raw < MIN_L) ? MIN_L : ((raw > MAX_L) ? MAX_L : raw);
        sel_prior = lfsr[LEN_W +: PRI_W];
        sel_dest  = lfsr[LEN_W+PRI_W +: PORT_W];
      end
      2'd2: begin
        if (first_pkt) begin
          sel_len   = MIN_L;
          sel_prior = '0;
          sel_dest  = '0;
        end else begin
          sel_len   = (cur_len >= MAX_L) ? MIN_L : cur_len + LEN_W'(1);
          sel_prior = cur_prior + PRI_W'(1);
          sel_dest  = cur_dest + PORT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Output decode for the state being entered; registered below so every
  // output changes only at the clock edge.
  always_comb begin
    sop_d  = (next_state == S_SOP);
    eop_d  = (next_state == S_EOP);
    beat_d = (next_state == S_BODY) && !pause;
    vld_d  = (next_state == S_HDR) || beat_d;
    busy_d = (next_state == S_SOP) || (next_state == S_HDR) ||
             (next_state == S_BODY) || (next_state == S_EOP);
    done_d = (next_state == S_DONE);
    data_d = '0;
    if (next_state == S_HDR) data_d = DATA_W'({cur_len, cur_prior, cur_dest});
    else if (beat_d)         data_d = DATA_W'(idx);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr      <= SEED_EFF;
      cur_len   <= '0;
      cur_prior <= '0;
      cur_dest  <= '0;
      idx       <= '0;
      total_q   <= '0;
      pkt_sent  <= '0;
      beat_sent <= '0;
      wr_sop    <= 1'b0;
      wr_eop    <= 1'b0;
      wr_vld    <= 1'b0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (accept) begin
        total_q   <= pkt_total;
        pkt_sent  <= '0;
        beat_sent <= '0;
      end
      if (next_state == S_SOP) begin
        cur_len   <= sel_len;
        cur_prior <= sel_prior;
        cur_dest  <= sel_dest;
        idx       <= '0;
        if (mode == 2'd1) lfsr <= lfsr_next;
      end
      if (beat_d) begin
        idx       <= idx + LEN_W'(1);
        beat_sent <= beat_sent + CNT_W'(1);
      end
      if (next_state == S_EOP) pkt_sent <= pkt_sent + CNT_W'(1);
      wr_sop  <= sop_d;
      wr_eop  <= eop_d;
      wr_vld  <= vld_d;
      wr_data <= data_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_hydra_pkt_gen.sv
// Self-checking bench for hydra_pkt_gen. A procedural reference model walks
// each expected packet beat by beat (sop, header, body with stalls, eop),
// choosing packet fields from the mode rules, and compares every cycle.
// A second instance with MAX_LEN=33 exercises incrementing-length wrap.
module tb_hydra_pkt_gen;

  localparam logic [31:0] SEED = 32'h1ACE_B00C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [8:0]  fixed_len = '0;
  logic [2:0]  fixed_prior = '0;
  logic [3:0]  fixed_dest = '0;
  logic [31:0] pkt_total = '0;
  logic        pause = 1'b0;

  logic        wr_sop, wr_eop, wr_vld, busy, done;
  logic [15:0] wr_data;
  logic [31:0] pkt_sent, beat_sent;
  logic        wr_sop_b, wr_eop_b, wr_vld_b, busy_b, done_b;
  logic [15:0] wr_data_b;
  logic [31:0] pkt_sent_b, beat_sent_b;

  always #5 clk = ~clk;

  hydra_pkt_gen dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .fixed_len(fixed_len),
    .fixed_prior(fixed_prior), .fixed_dest(fixed_dest), .pkt_total(pkt_total),
    .pause(pause), .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld),
    .wr_data(wr_data), .busy(busy), .done(done), .pkt_sent(pkt_sent),
    .beat_sent(beat_sent)
  );

  hydra_pkt_gen #(.MAX_LEN(33)) dut_b (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .fixed_len(fixed_len),
    .fixed_prior(fixed_prior), .fixed_dest(fixed_dest), .pkt_total(pkt_total),
    .pause(pause), .wr_sop(wr_sop_b), .wr_eop(wr_eop_b), .wr_vld(wr_vld_b),
    .wr_data(wr_data_b), .busy(busy_b), .done(done_b), .pkt_sent(pkt_sent_b),
    .beat_sent(beat_sent_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit use_b = 1'b0;

  // Reference model state.
  logic [31:0] m_lfsr;
  logic [8:0]  m_len;
  logic [2:0]  m_prior;
  logic [3:0]  m_dest;
  int          m_max = 511;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // {busy, done, sop, eop, vld, data}
  function automatic logic [20:0] obs();
    if (use_b) return {busy_b, done_b, wr_sop_b, wr_eop_b, wr_vld_b, wr_data_b};
    return {busy, done, wr_sop, wr_eop, wr_vld, wr_data};
  endfunction

  function automatic logic [63:0] cnt();
    if (use_b) return {pkt_sent_b, beat_sent_b};
    return {pkt_sent, beat_sent};
  endfunction

  function automatic logic [20:0] ev(input bit b, input bit d, input bit s,
                                     input bit e, input bit v, input logic [15:0] data);
    return {b, d, s, e, v, data};
  endfunction

  // Field choice for the next packet from the mode rules.
  task automatic model_next(input logic [1:0] md, input bit first,
                            output logic [8:0] len, output logic [2:0] pr, output logic [3:0] ds);
    int raw;
    case (md)
      2'd1: begin
        raw = int'(m_lfsr[8:0]);
        if (raw < 31) raw = 31;
        if (raw > m_max) raw = m_max;
        len = 9'(raw);
        pr  = m_lfsr[11:9];
        ds  = m_lfsr[15:12];
        m_lfsr = {1'b0, m_lfsr[31:1]} ^ (m_lfsr[0] ? 32'h8020_0003 : 32'd0);
      end
      2'd2: begin
        if (first) begin
          m_len = 9'd31; m_prior = 3'd0; m_dest = 4'd0;
        end else begin
          m_len   = (int'(m_len) >= m_max) ? 9'd31 : m_len + 9'd1;
          m_prior = m_prior + 3'd1;
          m_dest  = m_dest + 4'd1;
        end
        len = m_len; pr = m_prior; ds = m_dest;
      end
      default: begin
        len = (fixed_len == 9'd0) ? 9'd1 : fixed_len;
        pr  = fixed_prior;
        ds  = fixed_dest;
      end
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; pause = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'(obs()), 64'(0));
    check("reset_counters", cnt(), 64'(0));
    rst = 1'b0;
    m_lfsr = SEED;
  endtask

  // pmode: 0 no pause, 1 random pause, 2 pause for 3 edges after body beat 2.
  // abort_beats > 0 returns mid-body of the first packet.
  // stray pulses start (with another pkt_total) during the first header.
  task automatic run_pkts(input logic [1:0] md, input int total, input int pmode,
                          input int abort_beats, input bit stray, input int exp_cycles);
    logic [8:0]  len;
    logic [2:0]  pr;
    logic [3:0]  ds;
    logic [20:0] o;
    bit          p;
    int          i, cyc, beats, stall_left;
    mode = md; pkt_total = 32'(total);
    start = 1'b1;
    cyc = 0; beats = 0; p = 1'b0;
    for (int k = 0; k < total; k++) begin
      model_next(md, k == 0, len, pr, ds);
      @(negedge clk); start = 1'b0; cyc++;
      check("sop", 64'(obs()), 64'(ev(1, 0, 1, 0, 0, 16'h0)));
      pause = ($urandom_range(0, 3) == 0) && pmode == 1;
      @(negedge clk); cyc++;
      o = obs();
      check("hdr", 64'(o), 64'(ev(1, 0, 0, 0, 1, {len, pr, ds})));
      if (md == 2'd1) check("len_range", 64'(o[15:7] >= 9'd31 && o[15:7] <= 9'd511), 64'(1));
      if (stray && k == 0) begin start = 1'b1; pkt_total = 32'(total + 3); end
      p = (pmode == 1) && ($urandom_range(0, 3) == 0);
      pause = p;
      i = 0; stall_left = 0;
      while (i < int'(len)) begin
        @(negedge clk); start = 1'b0; pkt_total = 32'(total); cyc++;
        if (p) check("stall", 64'(obs()), 64'(ev(1, 0, 0, 0, 0, 16'h0)));
        else begin
          check("body", 64'(obs()), 64'(ev(1, 0, 0, 0, 1, 16'(i))));
          i++; beats++;
          if (pmode == 2 && i == 3 && k == 0) stall_left = 3;
        end
        if (abort_beats > 0 && i >= abort_beats) begin
          pause = 1'b0;
          return;
        end
        if (pmode == 2) begin
          p = (stall_left > 0);
          if (stall_left > 0) stall_left--;
        end else p = (pmode == 1) && ($urandom_range(0, 3) == 0);
        pause = p;
      end
      @(negedge clk); cyc++;
      check("eop", 64'(obs()), 64'(ev(1, 0, 0, 1, 0, 16'h0)));
      pause = (pmode == 1) && ($urandom_range(0, 3) == 0);
    end
    @(negedge clk); pause = 1'b0;
    check("done", 64'(obs()), 64'(ev(0, 1, 0, 0, 0, 16'h0)));
    check("counters", cnt(), {32'(total), 32'(beats)});
    if (exp_cycles > 0) check("run_cycles", 64'(cyc), 64'(exp_cycles));
  endtask

  initial begin
    // Fixed mode, two unpaused packets of 4, then restart from DONE with len 0 -> 1.
    do_reset();
    fixed_len = 9'd4; fixed_prior = 3'd5; fixed_dest = 4'd9;
    run_pkts(2'd0, 2, 0, 0, 1'b0, 14);
    fixed_len = 9'd0;
    run_pkts(2'd3, 1, 0, 0, 1'b0, 4);

    // Fixed len 8 with a 3-edge pause after beat 2.
    do_reset();
    fixed_len = 9'd8; fixed_prior = 3'd1; fixed_dest = 4'd2;
    run_pkts(2'd0, 1, 2, 0, 1'b0, 14);

    // Random mode with random pause; a stray start while busy must be ignored.
    do_reset();
    run_pkts(2'd1, 60, 1, 0, 1'b1, 0);

    // Incrementing mode on the MAX_LEN=33 instance.
    do_reset();
    use_b = 1'b1; m_max = 33;
    run_pkts(2'd2, 5, 1, 0, 1'b0, 0);
    use_b = 1'b0; m_max = 511;

    // Reset mid-body of packet 1, then a fresh random run replays from SEED.
    do_reset();
    run_pkts(2'd1, 3, 0, 5, 1'b0, 0);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort_outputs", 64'(obs()), 64'(0));
    check("abort_counters", cnt(), 64'(0));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_quiet", 64'(obs()), 64'(0));
    end
    m_lfsr = SEED;
    run_pkts(2'd1, 2, 1, 0, 1'b0, 0);

    // pkt_total = 0: straight to done, never busy, no sop; again from DONE.
    do_reset();
    pkt_total = 32'd0; mode = 2'd0;
    for (int r = 0; r < 2; r++) begin
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("zero_done", 64'(obs()), 64'(ev(0, 1, 0, 0, 0, 16'h0)));
      check("zero_counters", cnt(), 64'(0));
      repeat (3) @(negedge clk);
      check("zero_idle", 64'(obs()), 64'(ev(0, 1, 0, 0, 0, 16'h0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
